// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, wait-counter width and default storage depth.
package dmem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int CNT_W     = 4;
   localparam int DEF_WORDS = 1024;

endpackage

// File: rtl/dmem_array.sv
// Synchronous word-addressed RAM (WORDS x 32) with a byte write mask and a
// registered read port. A write and its read-back happen on the same edge:
// the read register captures the post-write (merged) word.
module dmem_array
   import dmem_resp_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    mask,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];
   logic [31:0] merged;

   // Word as it stands after this access: stored bytes replaced where masked
   always_comb begin
      merged = mem[idx];
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (mask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (en && we) mem[idx] <= merged;
   end

   // Read register holds data only for the response cycle, zero otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdata <= '0;
      else      rdata <= en ? merged : '0;
   end

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder (slave end of the MEM-stage interface).
// Accepts one request in IDLE, holds it for WAIT cycles, then commits the
// store / returns the load and strobes ready for one cycle.
// Build option: DMEM_RESP_BE_EN -- when defined, byte enables are honoured on
// stores; otherwise every store writes the full word.
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(WORDS);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;

   logic              from_in;
   logic              cur_we;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_be;
   logic [3:0]        cur_mask;
   logic              fault;
   logic              fire;

   // With WAIT=0 the access happens on the accepting edge, so the fields come
   // straight from the inputs; otherwise from the captured copy.
   assign from_in   = (state == ST_IDLE);
   assign cur_we    = from_in ? we    : we_q;
   assign cur_addr  = from_in ? addr  : addr_q;
   assign cur_wdata = from_in ? wdata : wdata_q;
   assign cur_be    = from_in ? be    : be_q;

`ifdef DMEM_RESP_BE_EN
   assign cur_mask = cur_be;
`else
   // Port kept for interface compatibility; full-word writes only
   assign cur_mask = cur_be | 4'b1111;
`endif

   assign fault = (cur_addr[1:0] != 2'b00) ||
                  ({2'b00, cur_addr[31:2]} >= 32'(WORDS));

   // Edge that enters RESP: the memory access is performed here
   assign fire = ((state == ST_IDLE) && req && (WAIT == 0)) ||
                 ((state == ST_WAIT) && (cnt == CNT_W'(1)));

   dmem_array #(.WORDS(WORDS), .AW(AW)) u_array (
      .clk   (clk),
      .rst   (rst),
      .en    (fire && !fault),
      .we    (cur_we),
      .mask  (cur_mask),
      .idx   (cur_addr[2 +: AW]),
      .wdata (cur_wdata),
      .rdata (rdata)
   );

   // Request FSM with wait counter and registered busy/ready/err
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         ready   <= 1'b0;
         err     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         ready <= fire;
         err   <= fire && fault;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  we_q    <= we;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  be_q    <= be;
                  cnt     <= CNT_W'(WAIT);
                  busy    <= 1'b1;
                  state   <= (WAIT == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= ST_RESP;
            end
            ST_RESP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one WAIT=2 instance for the main sequence and
// one WAIT=0 instance for back-to-back throughput.
module tb_dmem_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_a = 1'b0;
   logic        req_b = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;

   logic        busy_a, ready_a, err_a;
   logic [31:0] rdata_a;
   logic        busy_b, ready_b, err_b;
   logic [31:0] rdata_b;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   dmem_resp #(.WORDS(1024), .WAIT(2)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr),
      .wdata(wdata), .be(be), .busy(busy_a), .ready(ready_a),
      .rdata(rdata_a), .err(err_a)
   );

   dmem_resp #(.WORDS(1024), .WAIT(0)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr),
      .wdata(wdata), .be(be), .busy(busy_b), .ready(ready_b),
      .rdata(rdata_b), .err(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   // One transaction on dut_a, issued at a negedge; expects ready 3 cycles later
   task automatic xact(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_err);
      int n;
      bit seen;
      we = w; addr = a; wdata = d; be = b; req_a = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         req_a = 1'b0;
         n++;
         if (ready_a) seen = 1'b1;
      end
      chk({tag, "_lat"}, 32'(n), 32'd3);
      chk({tag, "_rdata"}, rdata_a, exp_rd);
      chk({tag, "_err"}, {31'd0, err_a}, {31'd0, exp_err});
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_be;
      int nready;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy",  {31'd0, busy_a},  32'd0);
      chk("rst_ready", {31'd0, ready_a}, 32'd0);
      chk("rst_rdata", rdata_a,          32'd0);
      chk("rst_err",   {31'd0, err_a},   32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Store then load
      xact("st10", 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
      xact("ld10", 1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);

      // Byte enables over an existing word
`ifdef DMEM_RESP_BE_EN
      exp_be = 32'hAA22CC44;
`else
      exp_be = 32'h11223344;
`endif
      xact("st14a", 1'b1, 32'h014, 32'hAABBCCDD, 4'hF,    32'hAABBCCDD, 1'b0);
      xact("st14b", 1'b1, 32'h014, 32'h11223344, 4'b0101, exp_be,       1'b0);
      xact("ld14",  1'b0, 32'h014, 32'h0,        4'hF,    exp_be,       1'b0);

      // Faults: misaligned and out of range; 0x010 untouched
      xact("ld13",   1'b0, 32'h013,  32'h0, 4'hF, 32'h0, 1'b1);
      xact("ld1000", 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1);
      xact("st13",   1'b1, 32'h011,  32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
      xact("ld10b",  1'b0, 32'h010,  32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

      // Inputs changed while busy are ignored
      we = 1'b1; addr = 32'h018; wdata = 32'h00000055; be = 4'hF; req_a = 1'b1;
      @(negedge clk);
      chk("hold_busy", {31'd0, busy_a}, 32'd1);
      addr = 32'h010; wdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("hold_noready", {31'd0, ready_a}, 32'd0);
      @(negedge clk);
      chk("hold_ready", {31'd0, ready_a}, 32'd1);
      chk("hold_rdata", rdata_a, 32'h00000055);
      req_a = 1'b0;
      @(negedge clk);
      xact("ld10c", 1'b0, 32'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
      xact("ld18",  1'b0, 32'h018, 32'h0, 4'hF, 32'h00000055, 1'b0);

      // Reset during WAIT aborts the store
      xact("st20a", 1'b1, 32'h020, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0);
      we = 1'b1; addr = 32'h020; wdata = 32'h12345678; be = 4'hF; req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      chk("abort_busy", {31'd0, busy_a}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_busy0",  {31'd0, busy_a},  32'd0);
      chk("abort_ready0", {31'd0, ready_a}, 32'd0);
      chk("abort_rdata0", rdata_a,          32'd0);
      chk("abort_err0",   {31'd0, err_a},   32'd0);
      @(negedge clk);
      rst = 1'b1;
      nready = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ready_a) nready++;
      end
      chk("abort_noready", 32'(nready), 32'd0);
      xact("ld20", 1'b0, 32'h020, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

      // WAIT=0 back-to-back: req held 6 cycles -> ready/busy every other cycle
      we = 1'b0; addr = 32'h010; be = 4'hF; req_b = 1'b1;
      nready = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 6) req_b = 1'b0;
         chk($sformatf("b2b_ready%0d", i), {31'd0, ready_b}, {31'd0, 1'(i % 2)});
         chk($sformatf("b2b_busy%0d", i),  {31'd0, busy_b},  {31'd0, 1'(i % 2)});
         if (ready_b) begin
            nready++;
            chk($sformatf("b2b_err%0d", i), {31'd0, err_b}, 32'd0);
         end
      end
      @(negedge clk);
      chk("b2b_idle", {31'd0, busy_b}, 32'd0);
      chk("b2b_count", 32'(nready), 32'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Multi-cycle data-memory responder: the slave end of the MEM-stage load/store interface. It accepts one request at a time from the pipeline's memory stage, holds it for a programmable number of wait states, then returns read data or commits the write, and pulses `ready` for one cycle. It sits beside the core as the replacement target for the single-cycle 4 KB data memory, so the stall logic can be exercised.

## Interface
- `WORDS`, 1024: storage depth in 32-bit words (4 KB).
- `WAIT`, 2: wait-state count between acceptance and response (0..15).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: request valid; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address.
- `wdata` in 32: store data.
- `be` in 4: byte enables, bit i covers `wdata[8i+7:8i]`.
- `busy` out 1: request in flight (state ≠ IDLE).
- `ready` out 1: one-cycle response strobe.
- `rdata` out 32: load data, valid while `ready`=1.
- `err` out 1: access fault, valid while `ready`=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req`=1 captures `we`, `addr`, `wdata`, `be`; loads the wait counter with `WAIT`; goes to WAIT, or directly to RESP when `WAIT`=0.
- WAIT: counter decrements each cycle; at 1 → RESP on the next edge. `req` is ignored.
- RESP: `ready`=1 for exactly one cycle; the next state is always IDLE.
- Fault: `addr[1:0]`≠0 or word index ≥ `WORDS` → `err`=1, `rdata`=0, no write.
- Store: committed on the edge entering RESP, masked by `be`. `rdata` returns the word's post-write value.
- Load: `rdata` is the word at `addr[31:2]`, registered on the edge entering RESP.
- Captured fields are stable for the whole transaction. The requester may drop `req` after acceptance.
- `req` held high through RESP starts a new transaction only from IDLE. Throughput is one request per `WAIT`+2 cycles.

## Timing
- Reset values: state IDLE, `busy`=0, `ready`=0, `rdata`=0, `err`=0, counter=0. Storage is not reset.
- Latency: `req` accepted at edge N → `ready` high in cycle N+`WAIT`+1.
- `busy` rises the cycle after acceptance and falls with the return to IDLE.
- Reset during WAIT aborts the transaction: no write is committed and no `ready` is issued.
- Reset asserted in the RESP cycle clears `ready` immediately. The write is already committed.
- `ready`, `rdata` and `err` are registered outputs with no combinational path from the inputs.

## Configuration
- `DMEM_RESP_BE_EN` defined: `be` is honoured on stores. A store with `be`=0 is a legal no-op that still returns `ready`.
- Undefined: `be` is ignored and every store writes the full word. The port stays present so the interface is identical.

## Structure
- Shared package: FSM state encoding (2-bit), wait-counter width constant (4), default `WORDS`.
- One sub-module, `dmem_array`: a synchronous word-addressed RAM (`WORDS`×32) with a 4-bit write mask and a registered read port.
- FSM, counter and fault check live in `dmem_resp`.

## Test plan
- Store then load, `WAIT`=2: store `0xDEADBEEF` to `0x010`, then load `0x010` → each `ready` 3 cycles after `req`, `rdata`=`0xDEADBEEF`, `err`=0.
- Byte enables, macro defined: store `0x11223344` with `be`=`4'b0101` over a word holding `0xAABBCCDD` → load returns `0xAA22CC44`. With the macro undefined → `0x11223344`.
- Faults: load `0x013` and load `0x1000` → `ready` with `err`=1 and `rdata`=0. The word at `0x010` is unchanged.
- `WAIT`=0 back-to-back: `req` held high for 6 cycles → 3 responses, `ready` every second cycle, `busy` toggling.
- Reset mid-operation: store `0x12345678` to `0x020`, drop `rst` low during WAIT → no `ready`, all outputs 0, later load of `0x020` returns the prior value.
- `req` during WAIT: change `addr` and `wdata` while `busy`=1 → the response reflects only the originally captured request.
